// File: rtl/accel_spi_reader.sv
// ADXL362 SPI master: powers the sensor into measurement mode, then periodically
// burst-reads the X/Y/Z 12-bit samples and latches them together with a valid pulse.
module accel_spi_reader #(
  parameter int CLK_DIV        = 25,
  parameter int STARTUP_CYCLES = 5000,
  parameter int SAMPLE_PERIOD  = 500000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        ACL_MISO,
  output logic        ACL_SCLK,
  output logic        ACL_MOSI,
  output logic        ACL_CSN,
  output logic [11:0] x_acc,
  output logic [11:0] y_acc,
  output logic [11:0] z_acc,
  output logic        data_valid,
  output logic        busy
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {ST_STARTUP, ST_INIT, ST_IDLE, ST_READ, ST_UPDATE} state_t;
  typedef enum logic [2:0] {PH_OFF, PH_SETUP, PH_LO, PH_HI, PH_HOLD, PH_GAP} phase_t;

  state_t            state, state_nxt;
  phase_t            phase;
  logic [DW-1:0]     div_cnt;
  logic [2:0]        bit_idx, byte_idx;
  logic [2:0]        nxt_bit, nxt_byte, last_byte;
  logic [SW-1:0]     st_cnt;
  logic [TW-1:0]     tmr;
  logic              tmr_en, tick;
  logic              miso_meta, miso_s;
  logic [7:0]        rx_sr;
  logic [7:0]        tx_cur, tx_nxt;
  logic              tx_bit_nxt;
  logic              is_read, half_done, gap_done, last_bit, start_xfer;
  logic [2:0][11:0]  raw_q, acc_q;
  logic [1:0]        ax;

  function automatic logic [7:0] tx_byte(input logic rd, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (rd) begin
      case (idx)
        3'd0:    b = 8'h0B;
        3'd1:    b = 8'h0E;
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    b = 8'h0A;
        3'd1:    b = 8'h2D;
        3'd2:    b = 8'h02;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign is_read    = (state == ST_READ);
  assign half_done  = (div_cnt == HALF_END);
  assign gap_done   = (phase == PH_GAP) && (div_cnt == GAP_END);
  assign tick       = tmr_en && (tmr == TW'(SAMPLE_PERIOD - 1));
  assign last_byte  = is_read ? 3'd7 : 3'd2;
  assign last_bit   = (bit_idx == 3'd7) && (byte_idx == last_byte);
  assign nxt_bit    = bit_idx + 3'd1;
  assign nxt_byte   = (bit_idx == 3'd7) ? byte_idx + 3'd1 : byte_idx;
  assign tx_cur     = tx_byte(is_read, byte_idx);
  assign tx_nxt     = tx_byte(is_read, nxt_byte);
  assign tx_bit_nxt = tx_nxt[3'd7 - nxt_bit];
  assign busy       = (phase != PH_OFF);
  // Data bytes 2..7 map to axis (byte/2 - 1); odd bytes carry the high nibble.
  assign ax         = byte_idx[2:1] - 2'd1;

  assign x_acc = acc_q[0];
  assign y_acc = acc_q[1];
  assign z_acc = acc_q[2];

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) {miso_s, miso_meta} <= 2'b00;
    else          {miso_s, miso_meta} <= {miso_meta, ACL_MISO};

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= ST_STARTUP;
    else          state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    start_xfer = 1'b0;
    case (state)
      ST_STARTUP: if (st_cnt == SW'(STARTUP_CYCLES - 1)) begin
        state_nxt  = ST_INIT;
        start_xfer = 1'b1;
      end
      ST_INIT:   if (gap_done) state_nxt = ST_IDLE;
      ST_IDLE:   if (tick) begin
        state_nxt  = ST_READ;
        start_xfer = 1'b1;
      end
      ST_READ:   if (gap_done) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn)                 st_cnt <= '0;
    else if (state == ST_STARTUP) st_cnt <= st_cnt + SW'(1);

  // Sample timer free-runs from the first IDLE entry; ticks outside IDLE are simply lost.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      tmr_en <= 1'b0;
      tmr    <= '0;
    end else if (state == ST_INIT && gap_done) begin
      tmr_en <= 1'b1;
      tmr    <= '0;
    end else if (tmr_en) begin
      tmr <= tick ? '0 : tmr + TW'(1);
    end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      phase    <= PH_OFF;
      div_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      rx_sr    <= '0;
      ACL_SCLK <= 1'b0;
      ACL_MOSI <= 1'b0;
      ACL_CSN  <= 1'b1;
    end else begin
      case (phase)
        PH_OFF: if (start_xfer) begin
          phase    <= PH_SETUP;
          ACL_CSN  <= 1'b0;
          div_cnt  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
        end
        PH_SETUP: if (half_done) begin
          phase    <= PH_LO;
          div_cnt  <= '0;
          ACL_MOSI <= tx_cur[7];
        end else div_cnt <= div_cnt + DW'(1);
        PH_LO: if (half_done) begin
          phase    <= PH_HI;
          div_cnt  <= '0;
          ACL_SCLK <= 1'b1;
          rx_sr    <= {rx_sr[6:0], miso_s};
        end else div_cnt <= div_cnt + DW'(1);
        PH_HI: if (half_done) begin
          div_cnt  <= '0;
          ACL_SCLK <= 1'b0;
          bit_idx  <= nxt_bit;
          byte_idx <= nxt_byte;
          if (last_bit) phase <= PH_HOLD;
          else begin
            phase    <= PH_LO;
            ACL_MOSI <= tx_bit_nxt;
          end
        end else div_cnt <= div_cnt + DW'(1);
        PH_HOLD: if (half_done) begin
          phase   <= PH_GAP;
          div_cnt <= '0;
          ACL_CSN <= 1'b1;
        end else div_cnt <= div_cnt + DW'(1);
        PH_GAP: if (div_cnt == GAP_END) begin
          phase   <= PH_OFF;
          div_cnt <= '0;
        end else div_cnt <= div_cnt + DW'(1);
        default: phase <= PH_OFF;
      endcase
    end

  // Raw bytes are staged here so the visible outputs only change together in UPDATE.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) raw_q <= '0;
    else if (is_read && phase == PH_HI && half_done && bit_idx == 3'd7 && byte_idx[2:1] != 2'b00) begin
      if (byte_idx[0]) raw_q[ax][11:8] <= rx_sr[3:0];
      else             raw_q[ax][7:0]  <= rx_sr;
    end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      acc_q      <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == ST_UPDATE);
      if (state == ST_UPDATE) acc_q <= raw_q;
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Directed bench for accel_spi_reader with a behavioural ADXL362-style SPI slave.
module tb_accel_spi_reader;
  localparam int CLK_DIV = 2;
  localparam int STARTUP = 10;
  localparam int PERIOD  = 400;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        ACL_MISO;
  logic        ACL_SCLK, ACL_MOSI, ACL_CSN, data_valid, busy;
  logic [11:0] x_acc, y_acc, z_acc;

  int checks = 0;
  int errors = 0;

  accel_spi_reader #(.CLK_DIV(CLK_DIV), .STARTUP_CYCLES(STARTUP), .SAMPLE_PERIOD(PERIOD)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ACL_MISO(ACL_MISO), .ACL_SCLK(ACL_SCLK),
    .ACL_MOSI(ACL_MOSI), .ACL_CSN(ACL_CSN), .x_acc(x_acc), .y_acc(y_acc), .z_acc(z_acc),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  // Slave: shifts MOSI in on SCLK rise and presents the next MISO bit right after it,
  // leaving a full bit time for the master's two-flop synchronizer at CLK_DIV=2.
  logic [7:0] resp     [0:7];
  logic [7:0] mosi_log [0:7];
  logic [7:0] mosi_sr;
  int s_edges = 0;

  always @(negedge ACL_CSN or posedge ACL_SCLK) begin
    if (ACL_SCLK) begin
      mosi_sr = {mosi_sr[6:0], ACL_MOSI};
      s_edges++;
      if (s_edges % 8 == 0 && s_edges <= 64) mosi_log[3'(s_edges / 8 - 1)] = mosi_sr;
      if (s_edges < 64) ACL_MISO = resp[3'(s_edges / 8)][3'(7 - s_edges % 8)];
    end else begin
      s_edges  = 0;
      ACL_MISO = resp[0][7];
    end
  end

  // Protocol / hold monitors, sampled 1 time unit after each rising edge.
  int cyc = 0, dv_cnt = 0;
  int falls[$];
  int v_sclk = 0, v_dv = 0, v_hold = 0, v_busy = 0, v_mosi = 0;
  logic prev_csn = 1'b1, prev_dv = 1'b0, prev_mosi = 1'b0, prev_rst = 1'b0;
  logic [35:0] prev_xyz = '0;

  always @(posedge HCLK) begin
    #1;
    cyc++;
    if (ACL_CSN && ACL_SCLK) v_sclk++;
    if (data_valid && prev_dv) v_dv++;
    if (data_valid) dv_cnt++;
    if (HRESETn && prev_rst && !data_valid && {x_acc, y_acc, z_acc} != prev_xyz) v_hold++;
    if (!ACL_CSN && !busy) v_busy++;
    if (ACL_SCLK && ACL_MOSI != prev_mosi) v_mosi++;
    if (prev_csn && !ACL_CSN) falls.push_back(cyc);
    prev_csn  = ACL_CSN;
    prev_dv   = data_valid;
    prev_mosi = ACL_MOSI;
    prev_rst  = HRESETn;
    prev_xyz  = {x_acc, y_acc, z_acc};
  end

  typedef struct {
    logic [7:0]  xl, xh, yl, yh, zl, zh;
    logic [11:0] ex, ey, ez;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic load_resp(input vec_t v);
    resp[0] = 8'hFF; resp[1] = 8'hFF;
    resp[2] = v.xl; resp[3] = v.xh; resp[4] = v.yl;
    resp[5] = v.yh; resp[6] = v.zl; resp[7] = v.zh;
  endtask

  task automatic release_and_init();
    int n = 0;
    bit ok = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    while (ACL_CSN && n < 100) begin
      @(posedge HCLK); #1; n++;
    end
    chk("startup_cycles", n, STARTUP);
    for (int k = 0; k < 500; k++) begin
      @(posedge HCLK); #1;
      if (ACL_CSN) begin ok = 1'b1; break; end
    end
    chk("init_done", ok, 1);
    chk("init_edges", s_edges, 24);
    chk("init_bytes", {mosi_log[0], mosi_log[1], mosi_log[2]}, 24'h0A2D02);
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge HCLK); #1;
      if (data_valid) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int dv_before;
    vecs[0] = '{8'h34, 8'hF1, 8'hFF, 8'hFF, 8'h00, 8'h08, 12'h134, 12'hFFF, 12'h800};
    vecs[1] = '{8'h00, 8'hA5, 8'h7F, 8'h07, 8'h01, 8'h00, 12'h500, 12'h77F, 12'h001};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000};
    vecs[3] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'hAA, 8'h05, 12'hFFF, 12'h000, 12'h5AA};
    load_resp(vecs[0]);

    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_pins", {ACL_CSN, ACL_SCLK, ACL_MOSI}, 3'b100);
    chk("rst_xyz", {x_acc, y_acc, z_acc}, 36'h0);
    chk("rst_flags", {data_valid, busy}, 2'b00);

    release_and_init();
    chk("init_xyz", {x_acc, y_acc, z_acc}, 36'h0);
    falls.delete();

    for (int i = 0; i < 4; i++) begin
      wait_dv(ok);
      chk("dv_seen", ok, 1);
      chk("x_acc", x_acc, vecs[i].ex);
      chk("y_acc", y_acc, vecs[i].ey);
      chk("z_acc", z_acc, vecs[i].ez);
      chk("rd_edges", s_edges, 64);
      chk("rd_cmd", {mosi_log[0], mosi_log[1]}, 16'h0B0E);
      chk("rd_dummy", {mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5], mosi_log[6], mosi_log[7]}, 48'h0);
      @(posedge HCLK); #1;
      chk("dv_one_cycle", data_valid, 0);
      if (i < 3) load_resp(vecs[i + 1]);
    end

    chk("read_falls", falls.size(), 4);
    for (int i = 0; i + 1 < falls.size(); i++) chk("read_interval", falls[i + 1] - falls[i], PERIOD);

    repeat (50) @(posedge HCLK);
    #1;
    chk("idle_busy", {busy, ACL_CSN}, 2'b01);

    // Reset in the middle of a read, after the 20th SCLK rise.
    load_resp(vecs[0]);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge HCLK); #1;
      if (!ACL_CSN) begin ok = 1'b1; break; end
    end
    chk("rd_start", ok, 1);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge HCLK); #1;
      if (s_edges >= 20) begin ok = 1'b1; break; end
    end
    chk("edge20", ok, 1);
    #2;
    dv_before = dv_cnt;
    HRESETn = 1'b0;
    #1;
    chk("midrst_pins", {ACL_CSN, ACL_SCLK}, 2'b10);
    chk("midrst_xyz", {x_acc, y_acc, z_acc}, 36'h0);
    chk("midrst_dv", data_valid, 0);
    repeat (3) @(posedge HCLK);
    release_and_init();
    chk("no_dv_across_rst", dv_cnt, dv_before);
    wait_dv(ok);
    chk("dv_after_rst", ok, 1);
    chk("x_after_rst", {x_acc, y_acc, z_acc}, {vecs[0].ex, vecs[0].ey, vecs[0].ez});

    chk("sclk_low_csn_high", v_sclk, 0);
    chk("dv_not_back_to_back", v_dv, 0);
    chk("xyz_hold", v_hold, 0);
    chk("busy_while_csn_low", v_busy, 0);
    chk("mosi_stable_sclk_high", v_mosi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
